// File: rtl/cpu_bus_arbiter.sv
// Two-client (instruction/data) arbiter in front of a single 32-bit memory port.
// Conflict policy: fixed data priority by default; CPU_BUS_ARB_ROUND_ROBIN_EN selects round-robin.
module cpu_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_we,
  input  logic        i_start,
  output logic [31:0] i_q,
  output logic        i_done,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_data,
  input  logic        d_we,
  input  logic        d_start,
  output logic [31:0] d_q,
  output logic        d_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  output logic        mem_start,
  input  logic [31:0] mem_q,
  input  logic        mem_done,
  output logic [2:0]  dbg_state
);

  // Handshake: a client holds x_start with stable addr/data/we until its one-cycle
  // x_done; the memory side sees mem_start high while busy until mem_done pulses.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [31:0] cap_q;
  logic        grant_i, grant_d, d_wins, busy;

`ifdef CPU_BUS_ARB_ROUND_ROBIN_EN
  logic last_d;

  // Reset leaves last-grant on instruction, so data wins the first conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_d <= 1'b0;
    end else if (grant_d) begin
      last_d <= 1'b1;
    end else if (grant_i) begin
      last_d <= 1'b0;
    end
  end

  assign d_wins = ~last_d;
`else
  assign d_wins = 1'b1;
`endif

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      grant_d = d_start & (~i_start | d_wins);
      grant_i = i_start & ~grant_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = BUSY_D;
        end else if (grant_i) begin
          state_next = BUSY_I;
        end
      end
      BUSY_I:  if (mem_done) state_next = RESP_I;
      BUSY_D:  if (mem_done) state_next = RESP_D;
      RESP_I:  state_next = IDLE;
      RESP_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == BUSY_I) || (state == BUSY_D);

  // Request fields are latched only at grant, so client inputs cannot disturb a transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      mem_addr <= 32'd0;
      mem_data <= 32'd0;
      mem_we   <= 1'b0;
      cap_q    <= 32'd0;
    end else begin
      state <= state_next;
      if (grant_d) begin
        mem_addr <= d_addr;
        mem_data <= d_data;
        mem_we   <= d_we;
      end else if (grant_i) begin
        mem_addr <= i_addr;
        mem_data <= i_data;
        mem_we   <= i_we;
      end
      if (busy && mem_done) begin
        cap_q <= mem_q;
      end
    end
  end

  assign mem_start = busy & ~mem_done;
  assign i_done    = (state == RESP_I);
  assign d_done    = (state == RESP_D);
  assign i_q       = i_done ? cap_q : 32'd0;
  assign d_q       = d_done ? cap_q : 32'd0;
  assign dbg_state = state;

endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 The block SHALL have no parameters; all data and address paths are fixed at 32 bits.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 i_addr / i_data  in  32 each  instruction-client word address / write data.
REQ-005 i_we / i_start  in  1 each  instruction-client write enable / request.
REQ-006 i_q / i_done  out  32 / 1  instruction-client read data / completion pulse.
REQ-007 d_addr / d_data  in  32 each  data-client word address / write data.
REQ-008 d_we / d_start  in  1 each  data-client write enable / request.
REQ-009 d_q / d_done  out  32 / 1  data-client read data / completion pulse.
REQ-010 mem_addr / mem_data  out  32 each  memory-side address / write data.
REQ-011 mem_we / mem_start  out  1 each  memory-side write enable / request.
REQ-012 mem_q / mem_done  in  32 / 1  memory-side read data / completion pulse.

Function
REQ-013 Client protocol: client holds x_start high with stable x_addr/x_data/x_we until x_done; x_done is a one-cycle pulse; client may reassert x_start the cycle after x_done.
REQ-014 FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
REQ-015 In IDLE, on a rising edge with any x_start high, the block SHALL latch the winner's addr/data/we into mem_addr/mem_data/mem_we and enter BUSY_I or BUSY_D.
REQ-016 mem_start SHALL equal (state is BUSY_I or BUSY_D) AND NOT mem_done, combinationally.
REQ-017 In BUSY_x, on an edge with mem_done high, the block SHALL capture mem_q into an internal register and enter RESP_x.
REQ-018 In RESP_x, x_done SHALL be high for exactly that cycle and x_q SHALL present the captured word; the next state SHALL be IDLE.
REQ-019 x_q SHALL be 32'd0 whenever x_done is low; the non-granted client's done SHALL stay low.
REQ-020 Minimum latency: x_start sampled at edge N, mem_start high in cycle N+1; with mem_done in N+1, x_done in cycle N+2.
REQ-021 Once granted, a transaction SHALL complete even if the client drops x_start mid-transaction; x_done still pulses.
REQ-022 mem_addr/mem_data/mem_we SHALL remain stable from grant until leaving BUSY_x, regardless of client inputs.
REQ-023 Writes: mem_q is ignored for capture content only by the client; the block SHALL still pulse x_done on write completion.
REQ-024 Addresses SHALL pass through unmodified (no shift or translation).
REQ-025 Simultaneous i_start and d_start in IDLE SHALL be resolved per REQ-030/031; the loser remains pending and is served on a later IDLE cycle.
REQ-026 x_start arriving during BUSY or RESP SHALL be ignored until the next IDLE cycle.

Reset
REQ-027 Reset SHALL force IDLE, all outputs to 0, the capture register to 0 and last-grant to instruction.
REQ-028 Reset during BUSY_x SHALL abandon the memory transaction: mem_start low from the next cycle and no x_done is produced for it.

Configuration
REQ-029 Macro CPU_BUS_ARB_ROUND_ROBIN_EN selects the conflict policy.
REQ-030 Without CPU_BUS_ARB_ROUND_ROBIN_EN: fixed priority, data client always wins a conflict.
REQ-031 With CPU_BUS_ARB_ROUND_ROBIN_EN: conflict winner is the client not granted last; last-grant updates on every grant; after reset the data client wins the first conflict.

Verification
REQ-032 Single read: i_start=1, i_addr=0x10, mem_done one cycle after mem_start with mem_q=0xDEADBEEF -> mem_addr=0x10, i_done one cycle with i_q=0xDEADBEEF, d_done stays 0.
REQ-033 Data write: d_start=1, d_we=1, d_addr=0x20, d_data=0x12345678, mem_done after 3 cycles -> mem_we=1, mem_data=0x12345678, mem_start high 3 cycles, d_done pulses once.
REQ-034 Conflict, fixed priority: i_start and d_start together, both held, mem_done 1 cycle latency -> data served first, instruction second; in round-robin build, order D, I, D, I over 4 requests.
REQ-035 Client abort: i_start dropped one cycle after grant -> mem_addr stable, transaction completes, i_done still pulses once.
REQ-036 Reset in BUSY_D -> mem_start low next cycle, d_done never asserts, next i_start served normally from IDLE.
